// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier sequencer that borrows the pipeline's shared ALU for
// each partial-product accumulation and stalls EX until the product is ready.
module mul_sequencer #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] ALU_ADD    = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    output logic                  alu_sel_o,
    output logic [3:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] product_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] m_reg;
    logic [DATA_WIDTH-1:0] q_reg;
    logic [DATA_WIDTH-1:0] p_reg;
    logic [DATA_WIDTH-1:0] product_reg;
    logic [5:0]            iter_count;
    logic                  q_zero;

    assign q_zero = (q_reg == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over everything, including a start seen in IDLE.
    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start_i) state_next = RUN;
                RUN:  if (q_zero)  state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reg       <= '0;
            q_reg       <= '0;
            p_reg       <= '0;
            product_reg <= '0;
            iter_count  <= '0;
        end else if (!flush_i) begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        m_reg      <= rs1_data_i;
                        q_reg      <= rs2_data_i;
                        p_reg      <= '0;
                        iter_count <= '0;
                    end
                end
                RUN: begin
                    if (!q_zero) begin
                        p_reg      <= alu_result_i;
                        m_reg      <= m_reg << 1;
                        q_reg      <= q_reg >> 1;
                        iter_count <= iter_count + 6'd1;
                    end else begin
                        product_reg <= p_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // ALU request lines stay at zero unless an accumulation step is underway.
    always_comb begin
        alu_op_o = '0;
        alu_a_o  = '0;
        alu_b_o  = '0;
        if (state == RUN && !q_zero) begin
            alu_op_o = ALU_ADD;
            alu_a_o  = p_reg;
            alu_b_o  = q_reg[0] ? m_reg : '0;
        end
    end

    assign busy_o    = (state == RUN);
    assign alu_sel_o = busy_o;
    assign done_o    = (state == DONE);
    assign product_o = product_reg;

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/product width.
REQ-002 SHALL have parameter ALU_ADD, default 4'b0000, ALU_Operation code for add.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  MUL instruction present in EX; sampled only in IDLE.
REQ-006 SHALL have port flush_i  input  1  synchronous abort of the current multiply.
REQ-007 SHALL have port rs1_data_i  input  DATA_WIDTH  multiplicand.
REQ-008 SHALL have port rs2_data_i  input  DATA_WIDTH  multiplier.
REQ-009 SHALL have port alu_result_i  input  DATA_WIDTH  combinational result of the shared ALU.
REQ-010 SHALL have port alu_sel_o  output  1  1 = ALU operands/op driven by this block.
REQ-011 SHALL have port alu_op_o  output  4  ALU_Operation code to the shared ALU.
REQ-012 SHALL have port alu_a_o  output  DATA_WIDTH  ALU operand A.
REQ-013 SHALL have port alu_b_o  output  DATA_WIDTH  ALU operand B.
REQ-014 SHALL have port busy_o  output  1  pipeline stall request.
REQ-015 SHALL have port done_o  output  1  one-cycle product-valid strobe.
REQ-016 SHALL have port product_o  output  DATA_WIDTH  low DATA_WIDTH bits of rs1*rs2.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE with internal registers M (multiplicand), Q (multiplier), P (accumulator) and a 6-bit iteration counter.
REQ-018 IDLE: start_i=1 and flush_i=0 at an edge SHALL load M=rs1_data_i, Q=rs2_data_i, P=0, counter=0, and go to RUN.
REQ-019 RUN with Q!=0: SHALL drive alu_a_o=P, alu_b_o=(Q[0] ? M : 0), alu_op_o=ALU_ADD; at the edge SHALL set P=alu_result_i, M=M<<1, Q=Q>>1 (logical), counter+1; stay in RUN.
REQ-020 RUN with Q==0: SHALL perform no update, copy P to product_o at the edge, and go to DONE.
REQ-021 RUN latency: rs2 with highest set bit k SHALL take k+2 RUN cycles; rs2=0 SHALL take 1 RUN cycle; maximum DATA_WIDTH+1 cycles.
REQ-022 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE unconditionally.
REQ-023 busy_o SHALL be 1 in RUN only; alu_sel_o SHALL equal busy_o.
REQ-024 Outside RUN, alu_op_o, alu_a_o and alu_b_o SHALL be 0.
REQ-025 product_o SHALL hold its value from DONE until the next DONE.
REQ-026 Products SHALL be truncated to DATA_WIDTH bits, with no overflow flag; results are identical for signed and unsigned operands.
REQ-027 start_i SHALL be ignored in RUN and DONE.
REQ-028 flush_i=1 in any state SHALL force IDLE at the next edge, with no done_o and product_o unchanged.
REQ-029 flush_i SHALL take priority over start_i when both are high in IDLE.
REQ-030 The counter SHALL never exceed DATA_WIDTH; it is observable for verification only.

Reset
REQ-031 reset low SHALL immediately force IDLE, with M=Q=P=0, counter=0, product_o=0, and busy_o=done_o=alu_sel_o=0, regardless of clk.
REQ-032 Reset asserted mid-RUN SHALL abandon the multiply; after release the block SHALL accept start_i on the first edge.

Verification
REQ-033 rs1=6, rs2=7, start pulse -> busy_o high 4 cycles, then done_o 1 cycle, product_o=42.
REQ-034 rs1=0x12345678, rs2=0 -> busy_o 1 cycle, done_o, product_o=0.
REQ-035 rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> busy_o 33 cycles, product_o=0x00000001, counter peaks at 32.
REQ-036 rs1=5, rs2=3; flush_i pulsed in 2nd RUN cycle -> IDLE next edge, no done_o, product_o keeps prior value; restart gives 15.
REQ-037 reset pulled low mid-RUN, off a clock edge -> all outputs 0 immediately; new start after release gives the correct product.
REQ-038 start_i held high through RUN and DONE -> exactly one multiply completes, and a second starts only from IDLE.
